// File: rtl/imem_boot_loader.sv
// Boot loader: holds the core in reset, streams a counted block of instruction
// words into its debug write port, then releases the core after a fixed hold.
module imem_boot_loader #(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 16,
  parameter int RST_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [XLEN-1:0]  base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_data,
  output logic             in_ready,
  output logic             dbg_wr_en,
  output logic [XLEN-1:0]  dbg_addr,
  output logic [XLEN-1:0]  dbg_instr,
  output logic             core_rst,
  output logic             busy,
  output logic             done
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              wr_q, wr_d;
  logic [XLEN-1:0]   daddr_q, daddr_d;
  logic [XLEN-1:0]   dinstr_q, dinstr_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              in_ready_s;
  logic              accept_s;

  // in_ready depends only on registered state so the host sees no input-to-output path
  assign in_ready_s = (state_q == ST_LOAD) && (rem_q != {CNT_W{1'b0}});
  assign accept_s   = in_valid && in_ready_s;

  // Next-state, address/count bookkeeping and registered-output values
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    hold_d   = hold_q;
    wr_d     = 1'b0;
    daddr_d  = daddr_q;
    dinstr_d = dinstr_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          addr_d  = {base_addr[XLEN-1:2], 2'b00};
          rem_d   = word_count;
          hold_d  = {HOLD_W{1'b0}};
          state_d = (word_count != {CNT_W{1'b0}}) ? ST_LOAD : ST_RELEASE;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          wr_d     = 1'b1;
          daddr_d  = addr_q;
          dinstr_d = in_data;
          addr_d   = addr_q + XLEN'(4);
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_RELEASE;
            hold_d  = {HOLD_W{1'b0}};
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        // RELEASE lasts exactly RST_HOLD cycles including its first cycle
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    core_rst_d = (state_d != ST_RUN);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RELEASE);
    done_d     = (state_q == ST_RELEASE) && (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= {XLEN{1'b0}};
      rem_q      <= {CNT_W{1'b0}};
      hold_q     <= {HOLD_W{1'b0}};
      wr_q       <= 1'b0;
      daddr_q    <= {XLEN{1'b0}};
      dinstr_q   <= {XLEN{1'b0}};
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      hold_q     <= hold_d;
      wr_q       <= wr_d;
      daddr_q    <= daddr_d;
      dinstr_q   <= dinstr_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign dbg_wr_en = wr_q;
  assign dbg_addr  = daddr_q;
  assign dbg_instr = dinstr_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
